// File: rtl/motion_vector_reconstruct.sv
// Motion-vector reconstruction: adds decoded deltas to the PMVs, wraps into the f_code range
// and emits one {horizontal, vertical} vector per completed component pair.
`ifndef INFO_MACRO_MOTION_VECTOR
`define INFO_MACRO_MOTION_VECTOR 14'h02A5
`endif

module motion_vector_reconstruct #(
    parameter int VEC_W = 13,
    parameter int TAG_W = 14
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [31:0]             Vector_Value_I,
    input  logic                    Vector_Write_En_I,
    input  logic [15:0]             F_Codes_I,
    input  logic                    PMV_Reset_I,
    output logic                    MV_Valid_O,
    output logic [1:0]              MV_Sel_O,
    output logic signed [VEC_W-1:0] MV_Horz_O,
    output logic signed [VEC_W-1:0] MV_Vert_O,
    output logic                    Error_O
);

    localparam int MAG_W = 13;
    localparam int SW    = VEC_W + 1;
    // Wide enough to hold the wrap range without overflowing
    localparam int EW    = VEC_W + 3;

    logic [TAG_W-1:0] word_tag;
    logic             tag_ok;

    // Stage A
    logic             a_valid_q;
    logic             a_r_q, a_s_q, a_t_q, a_res_q, a_sign_q;
    logic [MAG_W-1:0] a_mag_q;

    // Stage B
    logic                 b_valid_q;
    logic                 b_r_q, b_s_q, b_t_q;
    logic signed [SW-1:0] b_sum_q;
    logic [3:0]           b_rsize_q;

    logic                    pending_q;
    logic signed [VEC_W-1:0] horz_hold_q;
    logic signed [VEC_W-1:0] pmv_q [2][2][2];

    logic signed [SW-1:0] delta, pmv_ext, sum_d;
    logic [3:0]           f_code, rsize_d;
    logic                 f_bad, res_bad;

    logic signed [EW-1:0]    half, low, high, range, sum_ext, wrapped;
    logic signed [VEC_W-1:0] result;

    assign word_tag = Vector_Value_I[31 -: TAG_W];
    assign tag_ok   = (word_tag == TAG_W'(`INFO_MACRO_MOTION_VECTOR));

    always_comb begin
        delta = $signed({{(SW - MAG_W){1'b0}}, a_mag_q});
        if (a_sign_q) begin
            delta = -delta;
        end
        pmv_ext = SW'(pmv_q[a_r_q][a_s_q][a_t_q]);
        sum_d   = pmv_ext + delta;

        f_code = F_Codes_I[15:12];
        case ({a_s_q, a_t_q})
            2'b00:   f_code = F_Codes_I[15:12];
            2'b01:   f_code = F_Codes_I[11:8];
            2'b10:   f_code = F_Codes_I[7:4];
            default: f_code = F_Codes_I[3:0];
        endcase
        f_bad   = (f_code == 4'd0) || (f_code > 4'd9);
        rsize_d = f_bad ? 4'd0 : f_code - 4'd1;
        res_bad = a_res_q && (f_code == 4'd1);
    end

    always_comb begin
        half    = EW'(16) << b_rsize_q;
        low     = -half;
        high    = half - EW'(1);
        range   = half <<< 1;
        sum_ext = EW'(b_sum_q);
        wrapped = sum_ext;
        if (sum_ext < low) begin
            wrapped = sum_ext + range;
        end else if (sum_ext > high) begin
            wrapped = sum_ext - range;
        end
        result = wrapped[VEC_W-1:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_valid_q   <= 1'b0;
            a_r_q       <= 1'b0;
            a_s_q       <= 1'b0;
            a_t_q       <= 1'b0;
            a_res_q     <= 1'b0;
            a_sign_q    <= 1'b0;
            a_mag_q     <= '0;
            b_valid_q   <= 1'b0;
            b_r_q       <= 1'b0;
            b_s_q       <= 1'b0;
            b_t_q       <= 1'b0;
            b_sum_q     <= '0;
            b_rsize_q   <= '0;
            pending_q   <= 1'b0;
            horz_hold_q <= '0;
            MV_Valid_O  <= 1'b0;
            MV_Sel_O    <= 2'b00;
            MV_Horz_O   <= '0;
            MV_Vert_O   <= '0;
            Error_O     <= 1'b0;
            for (int r = 0; r < 2; r++)
                for (int s = 0; s < 2; s++)
                    for (int t = 0; t < 2; t++)
                        pmv_q[r][s][t] <= '0;
        end else if (PMV_Reset_I) begin
            // Overrides any stage-C write and drops a same-cycle strobe
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            pending_q  <= 1'b0;
            MV_Valid_O <= 1'b0;
            Error_O    <= 1'b0;
            for (int r = 0; r < 2; r++)
                for (int s = 0; s < 2; s++)
                    for (int t = 0; t < 2; t++)
                        pmv_q[r][s][t] <= '0;
        end else begin
            MV_Valid_O <= 1'b0;

            a_valid_q <= Vector_Write_En_I && tag_ok;
            if (Vector_Write_En_I) begin
                a_r_q    <= Vector_Value_I[17];
                a_s_q    <= Vector_Value_I[16];
                a_t_q    <= Vector_Value_I[15];
                a_res_q  <= Vector_Value_I[14];
                a_sign_q <= Vector_Value_I[13];
                a_mag_q  <= Vector_Value_I[12:0];
                if (!tag_ok) begin
                    Error_O <= 1'b1;
                end
            end

            b_valid_q <= a_valid_q;
            if (a_valid_q) begin
                b_r_q     <= a_r_q;
                b_s_q     <= a_s_q;
                b_t_q     <= a_t_q;
                b_sum_q   <= sum_d;
                b_rsize_q <= rsize_d;
                if (f_bad || res_bad) begin
                    Error_O <= 1'b1;
                end
            end

            if (b_valid_q) begin
                // Frame prediction: both R copies track the same value
                pmv_q[0][b_s_q][b_t_q] <= result;
                pmv_q[1][b_s_q][b_t_q] <= result;
                if (!b_t_q) begin
                    horz_hold_q <= result;
                    pending_q   <= 1'b1;
                    if (pending_q) begin
                        Error_O <= 1'b1;
                    end
                end else begin
                    MV_Horz_O  <= horz_hold_q;
                    MV_Vert_O  <= result;
                    MV_Sel_O   <= {b_r_q, b_s_q};
                    MV_Valid_O <= 1'b1;
                    pending_q  <= 1'b0;
                    if (!pending_q) begin
                        Error_O <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_motion_vector_reconstruct.sv
// Directed self-checking bench for motion_vector_reconstruct.
`ifndef INFO_MACRO_MOTION_VECTOR
`define INFO_MACRO_MOTION_VECTOR 14'h02A5
`endif

module tb_motion_vector_reconstruct;

    localparam logic [13:0] TAG = `INFO_MACRO_MOTION_VECTOR;

    logic              clock;
    logic              resetn;
    logic [31:0]       Vector_Value_I;
    logic              Vector_Write_En_I;
    logic [15:0]       F_Codes_I;
    logic              PMV_Reset_I;
    logic              MV_Valid_O;
    logic [1:0]        MV_Sel_O;
    logic signed [12:0] MV_Horz_O;
    logic signed [12:0] MV_Vert_O;
    logic              Error_O;

    int checks = 0;
    int errors = 0;

    motion_vector_reconstruct #(
        .VEC_W(13),
        .TAG_W(14)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .Vector_Value_I   (Vector_Value_I),
        .Vector_Write_En_I(Vector_Write_En_I),
        .F_Codes_I        (F_Codes_I),
        .PMV_Reset_I      (PMV_Reset_I),
        .MV_Valid_O       (MV_Valid_O),
        .MV_Sel_O         (MV_Sel_O),
        .MV_Horz_O        (MV_Horz_O),
        .MV_Vert_O        (MV_Vert_O),
        .Error_O          (Error_O)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input logic r, input logic s, input logic t,
                                        input logic res, input logic sign, input int mag);
        logic [12:0] m;
        m = 13'(mag);
        return {TAG, r, s, t, res, sign, m};
    endfunction

    // Back-to-back horizontal/vertical words; valid expected exactly 2 clocks after the second
    task automatic send_pair(input logic [31:0] w0, input logic [31:0] w1, input int eh,
                             input int ev, input int esel, input string tag);
        @(negedge clock);
        Vector_Value_I    = w0;
        Vector_Write_En_I = 1'b1;
        @(negedge clock);
        Vector_Value_I    = w1;
        @(negedge clock);
        Vector_Write_En_I = 1'b0;
        @(negedge clock);
        check({tag, "_early"}, MV_Valid_O, 0);
        @(negedge clock);
        check({tag, "_valid"}, MV_Valid_O, 1);
        check({tag, "_horz"}, MV_Horz_O, eh);
        check({tag, "_vert"}, MV_Vert_O, ev);
        check({tag, "_sel"}, MV_Sel_O, esel);
        @(negedge clock);
        check({tag, "_once"}, MV_Valid_O, 0);
    endtask

    task automatic send_one(input logic [31:0] w);
        @(negedge clock);
        Vector_Value_I    = w;
        Vector_Write_En_I = 1'b1;
        @(negedge clock);
        Vector_Write_En_I = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int seen;
        resetn            = 1'b0;
        Vector_Value_I    = '0;
        Vector_Write_En_I = 1'b0;
        F_Codes_I         = 16'h1111;
        PMV_Reset_I       = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("rst_valid", MV_Valid_O, 0);
        check("rst_horz", MV_Horz_O, 0);
        check("rst_vert", MV_Vert_O, 0);
        check("rst_sel", MV_Sel_O, 0);
        check("rst_err", Error_O, 0);

        // Basic pair, then zero-delta pairs read back both R copies
        send_pair(mkw(0, 0, 0, 0, 0, 5), mkw(0, 0, 1, 0, 1, 3), 5, -3, 0, "basic");
        send_pair(mkw(0, 0, 0, 0, 0, 0), mkw(0, 0, 1, 0, 0, 0), 5, -3, 0, "pmv_r0");
        send_pair(mkw(1, 0, 0, 0, 0, 0), mkw(1, 0, 1, 0, 0, 0), 5, -3, 2, "pmv_r1");
        check("basic_err", Error_O, 0);

        // Positive wrap with f_code[0][0]=2: range -32..31
        F_Codes_I = 16'h2111;
        send_pair(mkw(0, 0, 0, 0, 0, 25), mkw(0, 0, 1, 0, 0, 0), 30, -3, 0, "pre30");
        send_pair(mkw(0, 0, 0, 0, 0, 5), mkw(0, 0, 1, 0, 0, 0), -29, -3, 0, "poswrap");
        send_pair(mkw(0, 0, 0, 0, 0, 0), mkw(0, 0, 1, 0, 0, 0), -29, -3, 0, "poswrap_pmv");

        // Negative wrap with f_code[0][0]=3: range -64..63
        F_Codes_I = 16'h3111;
        send_pair(mkw(0, 0, 0, 0, 1, 31), mkw(0, 0, 1, 0, 0, 0), -60, -3, 0, "pre_m60");
        send_pair(mkw(0, 0, 0, 1, 1, 10), mkw(0, 0, 1, 0, 0, 0), 58, -3, 0, "negwrap");
        check("negwrap_err", Error_O, 0);

        // Backward vector on S=1 leaves S=0 PMVs alone
        send_pair(mkw(0, 1, 0, 0, 0, 2), mkw(0, 1, 1, 0, 0, 1), 2, 1, 1, "bwd");
        send_pair(mkw(0, 0, 0, 0, 0, 0), mkw(0, 0, 1, 0, 0, 0), 58, -3, 0, "fwd_kept");
        check("fwd_err", Error_O, 0);

        // Lone vertical word is a protocol error, and the error is sticky
        send_one(mkw(0, 0, 1, 0, 0, 0));
        check("lone_vert_err", Error_O, 1);
        send_one({~TAG, 18'h00007});
        send_pair(mkw(0, 0, 0, 0, 0, 0), mkw(0, 0, 1, 0, 0, 0), 58, -3, 0, "tag_drop");
        check("err_sticky", Error_O, 1);

        // PMV reset clears error and predictors
        @(negedge clock);
        PMV_Reset_I = 1'b1;
        @(negedge clock);
        PMV_Reset_I = 1'b0;
        check("pmvrst_err", Error_O, 0);
        send_pair(mkw(0, 0, 0, 0, 0, 0), mkw(0, 0, 1, 0, 0, 0), 0, 0, 0, "pmvrst_zero");

        // PMV reset while the vertical word sits in stage B
        send_pair(mkw(0, 0, 0, 0, 0, 4), mkw(0, 0, 1, 0, 0, 6), 4, 6, 0, "pre_kill");
        @(negedge clock);
        Vector_Value_I    = mkw(0, 0, 0, 0, 0, 1);
        Vector_Write_En_I = 1'b1;
        @(negedge clock);
        Vector_Value_I    = mkw(0, 0, 1, 0, 0, 1);
        @(negedge clock);
        Vector_Write_En_I = 1'b0;
        @(negedge clock);
        PMV_Reset_I = 1'b1;
        @(negedge clock);
        PMV_Reset_I = 1'b0;
        seen = 0;
        repeat (3) begin
            if (MV_Valid_O) seen = 1;
            @(negedge clock);
        end
        check("kill_no_pulse", seen, 0);
        send_pair(mkw(0, 0, 0, 0, 0, 0), mkw(0, 0, 1, 0, 0, 0), 0, 0, 0, "kill_zero");
        check("kill_err", Error_O, 0);

        // Asynchronous reset mid-pair
        send_pair(mkw(0, 0, 0, 0, 0, 3), mkw(0, 0, 1, 0, 0, 2), 3, 2, 0, "pre_rst");
        @(negedge clock);
        Vector_Value_I    = mkw(0, 0, 0, 0, 0, 1);
        Vector_Write_En_I = 1'b1;
        @(negedge clock);
        Vector_Value_I    = mkw(0, 0, 1, 0, 0, 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", MV_Valid_O, 0);
        check("arst_horz", MV_Horz_O, 0);
        check("arst_vert", MV_Vert_O, 0);
        check("arst_sel", MV_Sel_O, 0);
        check("arst_err", Error_O, 0);
        @(negedge clock);
        Vector_Write_En_I = 1'b0;
        resetn            = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (MV_Valid_O) seen = 1;
        end
        check("arst_no_pulse", seen, 0);
        send_pair(mkw(0, 0, 0, 0, 0, 0), mkw(0, 0, 1, 0, 0, 0), 0, 0, 0, "arst_zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
